// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the signed restoring divider.
//   div_state_e : FSM state encoding (IDLE, PREP, ITER, FIX, HOLD)
//   DIV_WIDTH   : default operand width in bits
//   cnt_width() : iteration counter width derived from an operand width
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_HOLD = 3'd4
    } div_state_e;

    localparam int DIV_WIDTH = 8;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   i_rem [W-1:0] : partial remainder R (always < i_mag)
//   i_quo [W-1:0] : quotient shift register Q (dividend bits shift out the top)
//   i_mag [W-1:0] : divisor magnitude M (unsigned, nonzero)
//   o_rem [W-1:0] : next remainder
//   o_quo [W-1:0] : next quotient, new bit in LSB
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_mag,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ok;
    logic             w_unused;

    // {R,Q} << 1: next dividend bit enters R. R < M <= 2^(W-1) keeps the
    // shifted value inside W bits; the extra bits only carry the trial sign.
    assign w_shift  = {i_rem, i_quo[WIDTH-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, i_mag};
    assign w_ok     = ~w_trial[WIDTH+1];

    assign o_rem    = w_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo    = {i_quo[WIDTH-2:0], w_ok};

    assign w_unused = ^{w_trial[WIDTH], w_shift[WIDTH]};

endmodule

// File: rtl/signed_divider.sv
// signed_divider: sequential signed restoring divider on the A/B register pair.
//   Clk              : clock, rising edge
//   Reset_Load_Clear : sync active-high reset; loads Bval <= SW, Aval <= 0
//   Run              : start request, one division per high level pulse
//   SW   [W-1:0]     : dividend on reset/load, divisor when a division starts
//   Aval [W-1:0]     : remainder (sign of dividend)
//   Bval [W-1:0]     : dividend / quotient (truncated toward zero)
//   Done             : result held and Run still high
//   DivZero          : last started division had divisor 0
//   Ovf              : last division was most-negative / -1
//   o_dbg_state      : current FSM state
// Handshake: Run is a level request; a division starts only from IDLE, and
// Run must be seen low in HOLD before the next start is accepted.
module signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_Load_Clear,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Done,
    output logic             DivZero,
    output logic             Ovf,
    output div_state_e       o_dbg_state
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_1  = {WIDTH{1'b1}};

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_aval, r_bval, r_rem, r_quo, r_mag;
    logic             r_sn, r_sd, r_ovf_pend;
    logic             r_done, r_dz, r_ovf;

    logic [WIDTH-1:0] w_abs_b, w_abs_sw, w_rem_nxt, w_quo_nxt;

    // Two's-complement magnitude read as unsigned: MOST_NEG maps to 2^(W-1).
    assign w_abs_b  = r_bval[WIDTH-1] ? -r_bval : r_bval;
    assign w_abs_sw = SW[WIDTH-1]     ? -SW     : SW;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_mag (r_mag),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge Clk) begin
        if (Reset_Load_Clear) begin
            r_state    <= S_IDLE;
            r_bval     <= SW;
            r_aval     <= '0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_mag      <= '0;
            r_sn       <= 1'b0;
            r_sd       <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Run) r_state <= S_PREP;
                end
                S_PREP: begin
                    r_sn       <= r_bval[WIDTH-1];
                    r_sd       <= SW[WIDTH-1];
                    r_quo      <= w_abs_b;
                    r_mag      <= w_abs_sw;
                    r_rem      <= '0;
                    r_cnt      <= '0;
                    r_ovf      <= 1'b0;
                    r_ovf_pend <= (r_bval == MOST_NEG) && (SW == MINUS_1);
                    if (SW == '0) begin
                        r_dz    <= 1'b1;
                        r_done  <= Run;
                        r_state <= S_HOLD;
                    end else begin
                        r_dz    <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    // Most-negative / -1 falls out naturally: Q = 2^(W-1)
                    // negates back to MOST_NEG and R = 0; only the flag is extra.
                    r_bval  <= (r_sn ^ r_sd) ? -r_quo : r_quo;
                    r_aval  <= r_sn ? -r_rem : r_rem;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= Run;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!Run) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Aval        = r_aval;
    assign Bval        = r_bval;
    assign Done        = r_done;
    assign DivZero     = r_dz;
    assign Ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_signed_divider.sv
module tb_signed_divider;
  import div_pkg::*;

  localparam int W = 8;
  localparam int LAT_MAX = 40;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         run = 1'b0;
  logic [W-1:0] sw  = '0;
  logic [W-1:0] aval, bval;
  logic         done, div_zero, ovf;
  div_state_e   dbg_state;

  always #5 clk = ~clk;

  signed_divider #(.WIDTH(W)) dut (
    .Clk              (clk),
    .Reset_Load_Clear (rst),
    .Run              (run),
    .SW               (sw),
    .Aval             (aval),
    .Bval             (bval),
    .Done             (done),
    .DivZero          (div_zero),
    .Ovf              (ovf),
    .o_dbg_state      (dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer division truncating toward zero,
  // remainder from %, results wrapped to W bits.
  task automatic ref_div(input int a, input int d, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic o);
    int qi, ri;
    qi = a / d;
    ri = a % d;
    q  = W'(qi);
    r  = W'(ri);
    o  = (qi > 127);
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens at negedge, away from the active edge.
  task automatic load(input logic [W-1:0] v);
    rst = 1'b1; run = 1'b0; sw = v;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_div(input logic [W-1:0] dsr, output int lat, output bit leak);
    logic [W-1:0] pa, pb;
    pa = aval; pb = bval;
    sw = dsr; run = 1'b1;
    lat = 0; leak = 1'b0;
    for (int i = 0; i < LAT_MAX; i++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (done) break;
      if (aval !== pa || bval !== pb) leak = 1'b1;
    end
  endtask

  task automatic stop_run();
    run = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat;
    bit leak;
    logic [W-1:0] mq, mr;
    logic mo;
    int a, d, qs, rs;
    logic [W-1:0] reps[4];

    vt[0] = '{8'd100, 8'd3,   8'd33,  8'd1,   1'b0, 1'b0, 11};
    vt[1] = '{8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 11};
    vt[2] = '{8'd7,   8'hFE,  8'hFD,  8'd1,   1'b0, 1'b0, 11};
    vt[3] = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 11};
    vt[4] = '{8'h55,  8'h00,  8'h55,  8'h00,  1'b1, 1'b0, 2};
    vt[5] = '{8'h80,  8'd1,   8'h80,  8'h00,  1'b0, 1'b0, 11};
    vt[6] = '{8'd127, 8'hFF,  8'h81,  8'h00,  1'b0, 1'b0, 11};
    vt[7] = '{8'd5,   8'd7,   8'h00,  8'd5,   1'b0, 1'b0, 11};
    vt[8] = '{8'hFB,  8'd7,   8'h00,  8'hFB,  1'b0, 1'b0, 11};
    vt[9] = '{8'h9C,  8'hF9,  8'h0E,  8'hFE,  1'b0, 1'b0, 11};

    @(negedge clk);

    // Reset state
    load(8'd100);
    chk("reset_bval", 32'(bval), 32'd100);
    chk("reset_aval", 32'(aval), 32'd0);
    chk("reset_flags", {29'd0, done, div_zero, ovf}, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));

    // Table-driven vectors
    foreach (vt[i]) begin
      load(vt[i].dvd);
      start_div(vt[i].dsr, lat, leak);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_no_leak", i), 32'(leak), 32'd0);
      chk($sformatf("v%0d_bval", i), 32'(bval), 32'(vt[i].q));
      chk($sformatf("v%0d_aval", i), 32'(aval), 32'(vt[i].r));
      chk($sformatf("v%0d_divzero", i), 32'(div_zero), 32'(vt[i].dz));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
      stop_run();
      chk($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
    end

    // Overflow followed by divide-by-zero on the held result
    load(8'h80);
    start_div(8'hFF, lat, leak);
    chk("ovf_bval", 32'(bval), 32'h80);
    chk("ovf_flag", 32'(ovf), 32'd1);
    stop_run();
    start_div(8'h00, lat, leak);
    chk("dz_after_ovf_lat", 32'(lat), 32'd2);
    chk("dz_after_ovf_flag", 32'(div_zero), 32'd1);
    chk("dz_after_ovf_ovf_clr", 32'(ovf), 32'd0);
    chk("dz_after_ovf_bval", 32'(bval), 32'h80);
    chk("dz_after_ovf_aval", 32'(aval), 32'h00);
    stop_run();

    // Repeated division: one division per Run pulse held 20 cycles
    reps = '{8'd50, 8'd25, 8'd12, 8'd6};
    foreach (reps[k]) exp_q.push_back(reps[k]);
    load(8'd100);
    for (int p = 0; p < 4; p++) begin
      sw = 8'd2; run = 1'b1;
      repeat (20) begin @(posedge clk); @(negedge clk); end
      chk($sformatf("rep%0d_bval", p), 32'(bval), 32'(exp_q.pop_front()));
      chk($sformatf("rep%0d_done", p), 32'(done), 32'd1);
      stop_run();
    end

    // Reset in the middle of ITER
    load(8'd100);
    sw = 8'd3; run = 1'b1;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    chk("abort_in_iter", 32'(dbg_state), 32'(S_ITER));
    rst = 1'b1; sw = 8'd9; run = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_bval", 32'(bval), 32'd9);
    chk("abort_aval", 32'(aval), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("abort_no_fix", 32'(bval), 32'd9);

    // Randomized pairs against the reference model
    for (int t = 0; t < 200; t++) begin
      a = $urandom_range(0, 255);
      do d = $urandom_range(0, 255); while (d == 0);
      a = int'($signed(W'(a)));
      d = int'($signed(W'(d)));
      load(W'(a));
      start_div(W'(d), lat, leak);
      ref_div(a, d, mq, mr, mo);
      chk($sformatf("rnd%0d_bval(%0d/%0d)", t, a, d), 32'(bval), 32'(mq));
      chk($sformatf("rnd%0d_aval(%0d/%0d)", t, a, d), 32'(aval), 32'(mr));
      chk($sformatf("rnd%0d_ovf", t), 32'(ovf), 32'(mo));
      qs = int'($signed(bval));
      rs = int'($signed(aval));
      if (!mo) begin
        chk($sformatf("rnd%0d_identity", t), 32'(qs * d + rs), 32'(a));
        chk($sformatf("rnd%0d_rem_bound", t),
            32'(((rs < 0) ? -rs : rs) < ((d < 0) ? -d : d)), 32'd1);
        chk($sformatf("rnd%0d_rem_sign", t),
            32'((rs == 0) || ((rs < 0) == (a < 0))), 32'd1);
      end
      stop_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
